// File: rtl/alarm_ctrl.sv
// alarm_ctrl: stores a user-set HH:MM alarm, compares it against the timer's
// BCD time and runs the ring / snooze state machine that drives buzzer and LED.
module alarm_ctrl #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic       clk_1Hz,
   input  logic       rst,
   input  logic       arm,
   input  logic       set_en,
   input  logic       set_sel,
   input  logic [3:0] data_h,
   input  logic [3:0] data_l,
   input  logic       stop,
   input  logic       snooze,
   input  logic [3:0] hour_h,
   input  logic [3:0] hour_l,
   input  logic [3:0] min_h,
   input  logic [3:0] min_l,
   input  logic [3:0] sec_h,
   input  logic [3:0] sec_l,
   output logic [3:0] al_hour_h,
   output logic [3:0] al_hour_l,
   output logic [3:0] al_min_h,
   output logic [3:0] al_min_l,
   output logic       armed,
   output logic       ringing,
   output logic       buzz,
   output logic [2:0] led
);

   localparam int RW = (RING_SECS   > 1) ? $clog2(RING_SECS)   : 1;
   localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;

   localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
   localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS - 1);
   localparam logic [2:0]    SNZ_MAX   = 3'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZING = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [RW-1:0] ring_cnt, ring_cnt_nxt;
   logic [SW-1:0] snz_cnt, snz_cnt_nxt;
   logic [2:0]    snooze_num, snooze_num_nxt;
   logic          buzz_nxt;
   logic [2:0]    led_nxt;

   logic hour_ok, min_ok, match;

   // BCD range checks for the load path; seconds must read 00 for a match
   always_comb begin
      hour_ok = ((data_h <= 4'd1) && (data_l <= 4'd9)) ||
                ((data_h == 4'd2) && (data_l <= 4'd3));
      min_ok  = (data_h <= 4'd5) && (data_l <= 4'd9);
      match   = (hour_h == al_hour_h) && (hour_l == al_hour_l) &&
                (min_h  == al_min_h)  && (min_l  == al_min_l)  &&
                (sec_h  == 4'd0)      && (sec_l  == 4'd0);
   end

   // Alarm time store; out-of-range loads leave the old value in place
   always_ff @(posedge clk_1Hz) begin
      if (rst) begin
         al_hour_h <= 4'd0;
         al_hour_l <= 4'd0;
         al_min_h  <= 4'd0;
         al_min_l  <= 4'd0;
      end else if (set_en) begin
         if (!set_sel && hour_ok) begin
            al_hour_h <= data_h;
            al_hour_l <= data_l;
         end else if (set_sel && min_ok) begin
            al_min_h <= data_h;
            al_min_l <= data_l;
         end
      end
   end

   // Next state, counters and next output values; arm=0 > stop > snooze > expiry > match
   always_comb begin
      state_nxt      = state;
      ring_cnt_nxt   = ring_cnt;
      snz_cnt_nxt    = snz_cnt;
      snooze_num_nxt = snooze_num;

      if (!arm) begin
         state_nxt = DISARMED;
      end else begin
         case (state)
            DISARMED: state_nxt = ARMED;
            ARMED: begin
               if (match) begin
                  state_nxt      = RINGING;
                  ring_cnt_nxt   = '0;
                  snooze_num_nxt = '0;
               end
            end
            RINGING: begin
               if (stop) begin
                  state_nxt = ARMED;
               end else if (snooze && (snooze_num < SNZ_MAX)) begin
                  state_nxt      = SNOOZING;
                  snz_cnt_nxt    = SNZ_LOAD;
                  snooze_num_nxt = snooze_num + 3'd1;
               end else if (ring_cnt == RING_LAST) begin
                  state_nxt = ARMED;
               end else begin
                  ring_cnt_nxt = ring_cnt + 1'b1;
               end
            end
            SNOOZING: begin
               if (stop) begin
                  state_nxt = ARMED;
               end else if (snz_cnt == '0) begin
                  state_nxt    = RINGING;
                  ring_cnt_nxt = '0;
               end else begin
                  snz_cnt_nxt = snz_cnt - 1'b1;
               end
            end
            default: state_nxt = DISARMED;
         endcase
      end

      // Idle states never carry counter history into the next event
      if (state_nxt == ARMED || state_nxt == DISARMED) begin
         ring_cnt_nxt   = '0;
         snz_cnt_nxt    = '0;
         snooze_num_nxt = '0;
      end

      // Ring pattern restarts at buzz=1 / led=001 on every entry to RINGING
      buzz_nxt = 1'b0;
      led_nxt  = 3'b000;
      case (state_nxt)
         RINGING: begin
            if (state == RINGING) begin
               buzz_nxt = ~buzz;
               led_nxt  = {led[1:0], led[2]};
            end else begin
               buzz_nxt = 1'b1;
               led_nxt  = 3'b001;
            end
         end
         SNOOZING: led_nxt = 3'b100;
         default: ;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_1Hz) begin
      if (rst) begin
         state      <= DISARMED;
         ring_cnt   <= '0;
         snz_cnt    <= '0;
         snooze_num <= '0;
         armed      <= 1'b0;
         ringing    <= 1'b0;
         buzz       <= 1'b0;
         led        <= 3'b000;
      end else begin
         state      <= state_nxt;
         ring_cnt   <= ring_cnt_nxt;
         snz_cnt    <= snz_cnt_nxt;
         snooze_num <= snooze_num_nxt;
         armed      <= (state_nxt != DISARMED);
         ringing    <= (state_nxt == RINGING);
         buzz       <= buzz_nxt;
         led        <= led_nxt;
      end
   end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed stimulus pushes the expected post-edge outputs into
// a queue; an independent monitor pops one entry per clock and compares.
module tb_alarm_ctrl;

   logic       clk_1Hz = 1'b0;
   logic       rst = 1'b1;
   logic       arm = 1'b0;
   logic       set_en = 1'b0;
   logic       set_sel = 1'b0;
   logic [3:0] data_h = 4'd0, data_l = 4'd0;
   logic       stop = 1'b0, snooze = 1'b0;
   logic [3:0] hour_h = 4'd0, hour_l = 4'd0, min_h = 4'd0, min_l = 4'd0;
   logic [3:0] sec_h = 4'd0, sec_l = 4'd0;
   logic [3:0] al_hour_h, al_hour_l, al_min_h, al_min_l;
   logic       armed, ringing, buzz;
   logic [2:0] led;

   alarm_ctrl #(.RING_SECS(5), .SNOOZE_SECS(3), .MAX_SNOOZE(1)) dut (
      .clk_1Hz(clk_1Hz), .rst(rst), .arm(arm),
      .set_en(set_en), .set_sel(set_sel), .data_h(data_h), .data_l(data_l),
      .stop(stop), .snooze(snooze),
      .hour_h(hour_h), .hour_l(hour_l), .min_h(min_h), .min_l(min_l),
      .sec_h(sec_h), .sec_l(sec_l),
      .al_hour_h(al_hour_h), .al_hour_l(al_hour_l), .al_min_h(al_min_h), .al_min_l(al_min_l),
      .armed(armed), .ringing(ringing), .buzz(buzz), .led(led)
   );

   always #5 clk_1Hz = ~clk_1Hz;

   typedef struct {
      string       name;
      logic        armed;
      logic        ringing;
      logic        buzz;
      logic [2:0]  led;
      logic [15:0] al;
   } exp_t;

   exp_t        sb[$];
   int          n_pass = 0;
   int          n_total = 0;
   logic [15:0] exp_al = 16'h0000;

   // Monitor: one expected record per clock edge, sampled 1 unit after the edge
   initial begin
      forever begin
         @(posedge clk_1Hz);
         #1;
         if (sb.size() > 0) begin
            exp_t e;
            logic [15:0] got_al;
            e = sb.pop_front();
            got_al = {al_hour_h, al_hour_l, al_min_h, al_min_l};
            n_total++;
            if (armed === e.armed && ringing === e.ringing && buzz === e.buzz &&
                led === e.led && got_al === e.al)
               n_pass++;
            else
               $display("FAIL %s: got armed=%b ringing=%b buzz=%b led=%b al=%h, want armed=%b ringing=%b buzz=%b led=%b al=%h",
                        e.name, armed, ringing, buzz, led, got_al,
                        e.armed, e.ringing, e.buzz, e.led, e.al);
         end
      end
   end

   // Push the outputs expected after the coming edge, then let that edge pass
   task automatic step(input string nm, input logic a, input logic r,
                       input logic b, input logic [2:0] l);
      exp_t e;
      e.name = nm; e.armed = a; e.ringing = r; e.buzz = b; e.led = l; e.al = exp_al;
      sb.push_back(e);
      @(negedge clk_1Hz);
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      {hour_h, hour_l} = h;
      {min_h, min_l}   = m;
      {sec_h, sec_l}   = s;
   endtask

   task automatic load(input logic sel, input logic [3:0] dh, input logic [3:0] dl);
      set_en = 1'b1; set_sel = sel; data_h = dh; data_l = dl;
   endtask

   initial begin
      @(negedge clk_1Hz);
      // Reset
      rst = 1'b1;
      step("reset0", 0, 0, 0, 3'b000);
      step("reset1", 0, 0, 0, 3'b000);
      rst = 1'b0;

      // Alarm loading with range checks (arm=0 keeps DISARMED)
      set_time(8'h12, 8'h34, 8'h56);
      load(0, 4'd2, 4'd4);                   step("ld_h24_rej", 0, 0, 0, 3'b000);
      load(0, 4'd2, 4'd3); exp_al = 16'h2300; step("ld_h23",    0, 0, 0, 3'b000);
      load(1, 4'd6, 4'd0);                   step("ld_m60_rej", 0, 0, 0, 3'b000);
      load(1, 4'd5, 4'd9); exp_al = 16'h2359; step("ld_m59",    0, 0, 0, 3'b000);
      load(0, 4'd0, 4'd7); exp_al = 16'h0759; step("ld_h07",    0, 0, 0, 3'b000);
      load(1, 4'd3, 4'd0); exp_al = 16'h0730; step("ld_m30",    0, 0, 0, 3'b000);
      set_en = 1'b0;

      // Arm and ring a full episode
      set_time(8'h07, 8'h29, 8'h59);
      arm = 1'b1;                   step("arm",       1, 0, 0, 3'b000);
      set_time(8'h07, 8'h30, 8'h00); step("ring_c1",  1, 1, 1, 3'b001);
      set_time(8'h07, 8'h30, 8'h01); step("ring_c2",  1, 1, 0, 3'b010);
                                    step("ring_c3",   1, 1, 1, 3'b100);
                                    step("ring_c4",   1, 1, 0, 3'b001);
                                    step("ring_c5",   1, 1, 1, 3'b010);
                                    step("ring_end",  1, 0, 0, 3'b000);
                                    step("idle",      1, 0, 0, 3'b000);

      // Snooze once, then a second snooze is ignored
      set_time(8'h07, 8'h30, 8'h00); step("s_ring1",  1, 1, 1, 3'b001);
      set_time(8'h07, 8'h30, 8'h01); step("s_ring2",  1, 1, 0, 3'b010);
      snooze = 1'b1;                 step("snz1",     1, 0, 0, 3'b100);
      snooze = 1'b0;                 step("snz2",     1, 0, 0, 3'b100);
                                    step("snz3",      1, 0, 0, 3'b100);
                                    step("rering1",   1, 1, 1, 3'b001);
      snooze = 1'b1;                 step("snz_ign",  1, 1, 0, 3'b010);
      snooze = 1'b0;                 step("rering3",  1, 1, 1, 3'b100);
                                    step("rering4",   1, 1, 0, 3'b001);
                                    step("rering5",   1, 1, 1, 3'b010);
                                    step("rering_end",1, 0, 0, 3'b000);

      // stop and snooze together: stop wins
      set_time(8'h07, 8'h30, 8'h00); step("p_ring1",  1, 1, 1, 3'b001);
      set_time(8'h07, 8'h30, 8'h01);
      stop = 1'b1; snooze = 1'b1;    step("p_stop",   1, 0, 0, 3'b000);
      stop = 1'b0; snooze = 1'b0;

      // Disarm while snoozing keeps the alarm time
      set_time(8'h07, 8'h30, 8'h00); step("d_ring1",  1, 1, 1, 3'b001);
      set_time(8'h07, 8'h30, 8'h01);
      snooze = 1'b1;                 step("d_snz",    1, 0, 0, 3'b100);
      snooze = 1'b0; arm = 1'b0;     step("disarm",   0, 0, 0, 3'b000);
      arm = 1'b1;                    step("rearm",    1, 0, 0, 3'b000);

      // Reset mid-ring loses the alarm time
      set_time(8'h07, 8'h30, 8'h00); step("r_ring1",  1, 1, 1, 3'b001);
      set_time(8'h07, 8'h30, 8'h01);
      rst = 1'b1; exp_al = 16'h0000; step("rst_ring", 0, 0, 0, 3'b000);
      rst = 1'b0;

      // Midnight wrap with alarm 00:00
      set_time(8'h23, 8'h59, 8'h59); step("m_arm",    1, 0, 0, 3'b000);
                                    step("m_wait",    1, 0, 0, 3'b000);
      set_time(8'h00, 8'h00, 8'h00); step("m_ring",   1, 1, 1, 3'b001);
      set_time(8'h00, 8'h00, 8'h01); step("m_ring2",  1, 1, 0, 3'b010);

      // Drain the scoreboard, bounded
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_1Hz);
      if (sb.size() > 0) begin
         n_total++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
